// File: rtl/rv_pkg.sv
// Shared constants and elaboration-time helpers for the fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN = 32;

    // Ceiling log2, used to size pointers and counters from DEPTH.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear that takes priority over push and pop.
// Latency: data pushed at an edge is visible at the head in the following cycle (no bypass).
// Backpressure: the caller must not push when full; a pop while empty is ignored.
module sync_fifo
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    input  logic                  clear,
    output logic [WIDTH-1:0]      head_dat,
    output logic [clog2(DEPTH):0] count
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign push_en  = push && !clear;
    assign pop_en   = pop && !clear && (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for storage, pointers and occupancy; clear empties the queue.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_en && !pop_en) begin
                count_d = count_q + CNT_ONE;
            end else if (!push_en && pop_en) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_en && count_q == FULL));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues PCs to imem, pairs in-order responses with their PC, buffers pairs for decode.
// Latency: request is combinational from PC; a response reaches IF_valid one cycle after imem_rvalid.
// Backpressure: PC_stall when buffered + outstanding (+ this issue) would reach DEPTH; decode uses valid/ready.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] PC,
    input  logic            PC_valid,
    output logic            PC_stall,
    input  logic            Flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            IF_valid,
    output logic [XLEN-1:0] IF_pc,
    output logic [XLEN-1:0] IF_instr,
    input  logic            ID_ready
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [AW:0]        outstanding_q, outstanding_d;
    logic [AW:0]        drop_cnt_q, drop_cnt_d;
    logic [AW:0]        owed_after;
    logic [AW:0]        tag_count;
    logic [AW:0]        fifo_count;
    logic [XLEN-1:0]    tag_head;
    logic [2*XLEN-1:0]  fifo_head;
    logic [AW+1:0]      used;
    logic               issue;
    logic               rsp_keep;
    logic               rsp_drop;
    logic               deq;

    // A wrong-path cycle never issues; reset also holds the request strobe low.
    assign issue     = PC_valid && !Flush && !RST;
    assign imem_req  = issue;
    assign imem_addr = PC;

    // Responses are kept only when no older wrong-path responses are still owed.
    assign rsp_keep = imem_rvalid && (drop_cnt_q == '0) && !Flush;
    assign rsp_drop = imem_rvalid && (drop_cnt_q != '0);
    assign deq      = IF_valid && ID_ready && !Flush;

    // Credit check uses occupancy before this cycle's dequeue, so it is conservative by one.
    assign used     = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign PC_stall = (used + {{(AW+1){1'b0}}, issue}) >= DEPTH_W;

    assign IF_valid = fifo_count != '0;
    assign IF_pc    = fifo_head[2*XLEN-1:XLEN];
    assign IF_instr = fifo_head[XLEN-1:0];

    // Outstanding/drop accounting: on a flush every response still owed after this edge is dropped.
    always_comb begin
        owed_after    = outstanding_q - (imem_rvalid ? ONE : '0);
        outstanding_d = owed_after + (issue ? ONE : '0);
        drop_cnt_d    = rsp_drop ? (drop_cnt_q - ONE) : drop_cnt_q;
        if (Flush) begin
            outstanding_d = owed_after;
            drop_cnt_d    = owed_after;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk      (CLK),
        .rst      (RST),
        .push     (issue),
        .push_dat (PC),
        .pop      (rsp_keep),
        .clear    (Flush),
        .head_dat (tag_head),
        .count    (tag_count)
    );

    sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (rsp_keep),
        .push_dat ({tag_head, imem_rdata}),
        .pop      (deq),
        .clear    (Flush),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (RST)
        !(imem_rvalid && outstanding_q == '0));
    a_no_tag_underflow: assert property (@(posedge CLK) disable iff (RST)
        !(rsp_keep && tag_count == '0));
    a_credit_respected: assert property (@(posedge CLK) disable iff (RST)
        !(PC_valid && !Flush && used >= DEPTH_W));

endmodule
